mux_sel_reg: RTL and testbench
==============================

Name: mux_sel_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input channel and on the output.
- Two selection modes: fixed selection by the S input, or round-robin arbitration among valid channels.
- Holds one output register stage, so it can sit between streaming producers and a single consumer in datapath pipelines.
- Successor to the combinational mux trees; adds width and channel generalisation, flow control and fairness.

Parameters:
- N, 4, number of input channels (≥1).
- W, 2, data width per channel (≥1).
- SELW, derived: max(1, clog2(N)), width of select and channel-index fields; not overridable.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- I  input  N*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- I_VALID  input  N  per-channel valid.
- I_READY  output  N  per-channel ready; combinational, at most one bit high.
- S  input  SELW  channel select, used only when MODE=0.
- MODE  input  1  0 = fixed select by S; 1 = round-robin.
- O  output  W  registered output data.
- O_VALID  output  1  output register holds valid data.
- O_READY  input  1  consumer accepts O this cycle.

Behaviour:
- Reset (ASYNCRESETN low, takes effect immediately): O=0, O_VALID=0, round-robin pointer PTR=0. I_READY is all zeros while reset is asserted.
- can_load = !O_VALID | O_READY.
- Grant is combinational: grant index g, and grant_valid.
- MODE=0:
  - g=S; grant_valid = (S<N) & I_VALID[S].
  - S≥N grants nothing; no transfer occurs and no error is flagged.
- MODE=1:
  - g is the first k with I_VALID[k]=1, scanning PTR, PTR+1, …, N-1, 0, …, PTR-1.
  - grant_valid = |I_VALID.
- I_READY[g] = can_load & grant_valid. All other I_READY bits are 0.
- Input transfer on channel g: I_VALID[g] & I_READY[g]. On that edge, O ← channel g data and O_VALID ← 1.
- Output transfer: O_VALID & O_READY.
  - If there is an output transfer and no input transfer, O_VALID ← 0 and O holds its last value.
- Simultaneous output transfer and input transfer: the new data loads and O_VALID stays 1. Full throughput is one word per cycle.
- O_VALID=1 & O_READY=0: O and O_VALID hold, and all I_READY bits are 0 (backpressure).
- PTR updates only on an input transfer in MODE=1: PTR ← (g+1) mod N, wrapping from N-1 to 0. In MODE=0 and on idle cycles, PTR holds.
- MODE and S are sampled combinationally every cycle. A mode change affects the next grant decision; the pending output register content is unaffected.
- N=1: the block is a one-stage register slice; S and MODE are ignored and channel 0 is always the candidate.
- Latency: 1 cycle from input transfer to O_VALID.
- Data is not modified; there is no width conversion.
- Reset asserted mid-stream: the pending output word is discarded and PTR returns to 0.

Optional Feature:
- Macro: MUX_SEL_REG_CHAN_EN.
- Defined: adds output port O_CHAN (SELW bits). O_CHAN is loaded with g on every input transfer, held otherwise, and resets to 0. It is valid when O_VALID=1.
- Undefined: the O_CHAN port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then MODE=0, S=2, I_VALID=4'b0100, ch2=2'b11, O_READY=1. Required: I_READY=4'b0100; next cycle O=2'b11, O_VALID=1; O_CHAN=2 when the macro is defined.
- MODE=0, S=1, I_VALID=4'b1101 (ch1 not valid). Required: I_READY=0 and O_VALID stays 0. Then N=3, S=3 with all channels valid. Required: no grant.
- MODE=1, all four channels valid, O_READY=1 for 8 cycles. Required: outputs come from channels 0,1,2,3,0,1,2,3 at one per cycle; PTR wraps 3→0.
- MODE=1, PTR=2, I_VALID=4'b0011. Required: grant ch0 (wrap search), then ch1, then ch0.
- O_VALID=1, O_READY=0 for 3 cycles with ch0 data changing. Required: O stable and I_READY=0. Then O_READY=1 with ch0 valid. Required: same-cycle drain and load; O_VALID stays 1.
- ASYNCRESETN pulsed low between clock edges while O_VALID=1. Required: O_VALID=0 and O=0 immediately, before the next edge. After release, round-robin restarts from ch0.

Source files
------------

// File: rtl/mux_sel_reg_if.sv
// Stream bundle for mux_sel_reg: N input channels plus one registered output channel.
// Carries data, per-channel valid/ready, select controls and the output handshake.
// O_CHAN exists only when MUX_SEL_REG_CHAN_EN is defined.
interface mux_sel_reg_if #(
    parameter int N = 4,
    parameter int W = 2
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0]  I;
    logic [N-1:0]    I_VALID;
    logic [N-1:0]    I_READY;
    logic [SELW-1:0] S;
    logic            MODE;
    logic [W-1:0]    O;
    logic            O_VALID;
    logic            O_READY;
`ifdef MUX_SEL_REG_CHAN_EN
    logic [SELW-1:0] O_CHAN;
`endif

    // Mux side: consumes channel inputs, drives readies and the output register.
    modport slave (
        input  I, I_VALID, S, MODE, O_READY,
`ifdef MUX_SEL_REG_CHAN_EN
        output O_CHAN,
`endif
        output I_READY, O, O_VALID
    );

    // Environment side: producers and the single consumer.
    modport master (
        output I, I_VALID, S, MODE, O_READY,
`ifdef MUX_SEL_REG_CHAN_EN
        input  O_CHAN,
`endif
        input  I_READY, O, O_VALID
    );
endinterface

// File: rtl/mux_sel_reg.sv
// N-channel W-bit registered mux, fixed select (MODE=0) or round-robin (MODE=1); MUX_SEL_REG_CHAN_EN adds O_CHAN.
// Latency: 1 cycle from input transfer to O_VALID; one word per cycle sustained.
// Backpressure: granted channel sees I_READY only when the output register is empty or draining.
module mux_sel_reg #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic           CLK,
    input  logic           ASYNCRESETN,
    mux_sel_reg_if.slave   bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]    o_dat_q, o_dat_d;
    logic            o_vld_q, o_vld_d;
    logic [SELW-1:0] ptr_q, ptr_d;
`ifdef MUX_SEL_REG_CHAN_EN
    logic [SELW-1:0] chan_q, chan_d;
`endif

    logic [SELW-1:0] grant_idx;
    logic            grant_vld;
    logic [W-1:0]    sel_dat;
    logic            can_load;
    logic            in_xfer;

    // Grant decision: fixed select or rotating-priority scan starting at ptr_q.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        if (N == 1) begin
            // Single channel: plain register slice, select controls ignored.
            grant_vld = bus.I_VALID[0];
        end else if (!bus.MODE) begin
            // Out-of-range select matches no channel and so grants nothing.
            grant_idx = bus.S;
            for (int k = 0; k < N; k++) begin
                if (SELW'(k) == bus.S) begin
                    grant_vld = bus.I_VALID[k];
                end
            end
        end else begin
            // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
            for (int k = 0; k < N; k++) begin
                if (!grant_vld && (k >= int'(ptr_q)) && bus.I_VALID[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!grant_vld && (k < int'(ptr_q)) && bus.I_VALID[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(k);
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (SELW'(k) == grant_idx) begin
                sel_dat = bus.I[k*W +: W];
            end
        end
    end

    // Handshake: one-hot ready toward the granted channel, forced low during reset.
    always_comb begin
        can_load    = !o_vld_q || bus.O_READY;
        in_xfer     = ASYNCRESETN && can_load && grant_vld;
        bus.I_READY = '0;
        for (int k = 0; k < N; k++) begin
            if (SELW'(k) == grant_idx) begin
                bus.I_READY[k] = in_xfer;
            end
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        o_dat_d = o_dat_q;
        o_vld_d = o_vld_q;
        ptr_d   = ptr_q;
`ifdef MUX_SEL_REG_CHAN_EN
        chan_d  = chan_q;
`endif
        if (in_xfer) begin
            o_dat_d = sel_dat;
            o_vld_d = 1'b1;
`ifdef MUX_SEL_REG_CHAN_EN
            chan_d  = grant_idx;
`endif
            // Pointer only advances on round-robin transfers; fixed mode leaves it alone.
            if (bus.MODE && (N > 1)) begin
                ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (o_vld_q && bus.O_READY) begin
            // Drain without refill: data is kept, only valid drops.
            o_vld_d = 1'b0;
        end
    end

    // State registers; reset discards any pending word.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            o_dat_q <= '0;
            o_vld_q <= 1'b0;
            ptr_q   <= '0;
`ifdef MUX_SEL_REG_CHAN_EN
            chan_q  <= '0;
`endif
        end else begin
            o_dat_q <= o_dat_d;
            o_vld_q <= o_vld_d;
            ptr_q   <= ptr_d;
`ifdef MUX_SEL_REG_CHAN_EN
            chan_q  <= chan_d;
`endif
        end
    end

    assign bus.O       = o_dat_q;
    assign bus.O_VALID = o_vld_q;
`ifdef MUX_SEL_REG_CHAN_EN
    assign bus.O_CHAN  = chan_q;
`endif
endmodule

// File: tb/tb_mux_sel_reg.sv
// Scoreboard bench for mux_sel_reg: directed scenarios then randomized traffic.
// Expected words come from a queue-based reference model; a monitor pops on output transfers.
module tb_mux_sel_reg;
    logic CLK;
    logic rst_n;

    mux_sel_reg_if #(.N(4), .W(2)) bus ();
    mux_sel_reg_if #(.N(3), .W(2)) bus3 ();

    mux_sel_reg #(.N(4), .W(2)) dut (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus));
    mux_sel_reg #(.N(3), .W(2)) dut3 (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus3));

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_ov   = 0;
    int   m_ptr  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference grant: fixed select, or first valid channel scanning from the pointer with wrap.
    function automatic void model_grant(input logic m, input int s, input logic [3:0] v,
                                        output int g, output bit gv);
        int k;
        g  = 0;
        gv = 0;
        if (!m) begin
            g  = s;
            gv = (s < 4) && v[s];
        end else begin
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (!gv && v[k]) begin
                    gv = 1;
                    g  = k;
                end
            end
        end
    endfunction

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge CLK) begin
        if (rst_n && bus.O_VALID && bus.O_READY) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(bus.O_VALID), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_data", 32'(bus.O), 32'(e.d));
`ifdef MUX_SEL_REG_CHAN_EN
                chk("out_chan", 32'(bus.O_CHAN), 32'(e.c));
`endif
            end
        end
    end

    // One cycle: drive, check ready/valid against the model, advance the model.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic [7:0] d, input logic ordy);
        int   g;
        bit   gv;
        bit   cl;
        bit   xfer;
        logic [3:0] exp_rdy;
        exp_t e;
        bus.MODE    = m;
        bus.S       = s;
        bus.I_VALID = v;
        bus.I       = d;
        bus.O_READY = ordy;
        #1;
        model_grant(m, int'(s), v, g, gv);
        cl      = !m_ov || ordy;
        xfer    = cl && gv;
        exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
        chk("i_ready", 32'(bus.I_READY), 32'(exp_rdy));
        chk("o_valid", 32'(bus.O_VALID), 32'(m_ov));
        if (m_ov && q.size() > 0) chk("o_hold", 32'(bus.O), 32'(q[0].d));
        if (xfer) begin
            e.d = d[g*2 +: 2];
            e.c = g[1:0];
            q.push_back(e);
            if (m) m_ptr = (g + 1) % 4;
        end
        m_ov = xfer ? 1'b1 : (ordy ? 1'b0 : m_ov);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.I = '0;  bus.I_VALID = '0;  bus.S = '0;  bus.MODE = 1'b0;  bus.O_READY = 1'b1;
        bus3.I = '0; bus3.I_VALID = '0; bus3.S = '0; bus3.MODE = 1'b0; bus3.O_READY = 1'b1;
        rst_n = 1'b0;
        #2;
        bus.I_VALID = 4'hF;
        #1;
        // Reset state: outputs cleared, no ready even with all inputs valid.
        chk("rst_o_valid", 32'(bus.O_VALID), 32'(0));
        chk("rst_o", 32'(bus.O), 32'(0));
        chk("rst_i_ready", 32'(bus.I_READY), 32'(0));
`ifdef MUX_SEL_REG_CHAN_EN
        chk("rst_o_chan", 32'(bus.O_CHAN), 32'(0));
`endif
        bus.I_VALID = '0;
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // Fixed select S=2 with only channel 2 valid, then an idle drain.
        step(1'b0, 2'd2, 4'b0100, 8'b0011_0000, 1'b1);
        chk("first_o", 32'(bus.O), 32'(2'b11));
        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1);
        // Selected channel not valid: no grant.
        step(1'b0, 2'd1, 4'b1101, 8'hFF, 1'b1);
        step(1'b0, 2'd1, 4'b1101, 8'hFF, 1'b1);

        // Three-channel instance: S=3 is out of range and grants nothing.
        bus3.MODE = 1'b0; bus3.S = 2'd3; bus3.I_VALID = 3'b111; bus3.I = 6'b11_10_01;
        #1;
        chk("n3_oob_ready", 32'(bus3.I_READY), 32'(0));
        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1);
        chk("n3_oob_valid", 32'(bus3.O_VALID), 32'(0));
        bus3.S = 2'd2;
        #1;
        chk("n3_s2_ready", 32'(bus3.I_READY), 32'(3'b100));
        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1);
        chk("n3_s2_valid", 32'(bus3.O_VALID), 32'(1));
        chk("n3_s2_data", 32'(bus3.O), 32'(2'b11));
        bus3.I_VALID = '0;

        // Round-robin, all valid, full throughput: 0,1,2,3,0,1,2,3.
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 8'h00, 1'b1);

        // Move pointer to 2, then wrap search over channels 0 and 1.
        step(1'b1, 2'd0, 4'b0010, 8'b00_00_10_00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b0011, 8'b00_00_10_01, 1'b1);
        step(1'b1, 2'd0, 4'b0000, 8'h00, 1'b1);

        // Backpressure: hold for three cycles while channel 0 data changes, then drain+load.
        step(1'b0, 2'd0, 4'b0001, 8'h01, 1'b1);
        step(1'b0, 2'd0, 4'b0001, 8'h02, 1'b0);
        step(1'b0, 2'd0, 4'b0001, 8'h03, 1'b0);
        step(1'b0, 2'd0, 4'b0001, 8'h00, 1'b0);
        step(1'b0, 2'd0, 4'b0001, 8'h02, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b0);

        // Asynchronous reset between edges while a word is pending.
        step(1'b1, 2'd0, 4'b0100, 8'b00_11_00_00, 1'b0);
        bus.I_VALID = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o_valid", 32'(bus.O_VALID), 32'(0));
        chk("mid_rst_o", 32'(bus.O), 32'(0));
        chk("mid_rst_i_ready", 32'(bus.I_READY), 32'(0));
        #1;
        rst_n = 1'b1;
        q.delete();
        m_ov  = 0;
        m_ptr = 0;
        @(posedge CLK);
        #1;
        step(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1);
        step(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1);

        // Randomized traffic with random mode changes and consumer stalls.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                 8'($urandom), ($urandom_range(0, 3) != 0));
        end

        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 8'h00, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
